// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: state encoding, default timeout and grant-index sizing shared by the arbiter files
package uart_tx_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;
    localparam int DEFAULT_TIMEOUT = 400000;
    function automatic int grant_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: start/data/busy/done link between the arbiter and a single uart_tx
interface uart_tx_arbiter_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_done;
    modport master (output tx_start, tx_data, input tx_busy, tx_done);
    modport slave (input tx_start, tx_data, output tx_busy, tx_done);
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search starting just after the last winner
module rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N = 4,
    parameter int W = grant_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] idx,
    output logic         any
);
    logic [W:0]   sh;
    logic [N-1:0] rot;
    assign sh  = {1'b0, last} + 1'b1;
    assign rot = N'({req, req} >> sh);
    assign any = |req;
    always_comb begin
        idx = '0;
        // rot[0] is the requester right after last; scan downward so the lowest set bit wins
        for (int k = N - 1; k >= 0; k--)
            if (rot[k]) idx = W'((int'(last) + 1 + k) % N);
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among NREQ byte requesters,
// with a busy/done watchdog that abandons a stalled frame.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    localparam int W      = grant_w(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [8*NREQ-1:0]    req_data,
    output logic [NREQ-1:0]      req_ready,
    uart_tx_arbiter_if.master    uart,
    output logic [W-1:0]         grant_id,
    output logic                 done,
    output logic                 err
);
    state_t       state, state_nx;
    logic [W-1:0] last, win;
    logic [31:0]  cnt;
    logic [7:0]   lane [NREQ];
    logic         any, grant, waiting, fin, tmo;

    rr_pick #(.N(NREQ), .W(W)) u_pick (.req(req_valid), .last(last), .idx(win), .any(any));

    always_comb begin
        for (int i = 0; i < NREQ; i++) lane[i] = req_data[8*i +: 8];
    end

    // done/err block the grant so an idle cycle always follows frame completion
    always_comb begin
        waiting  = state == WAIT_BUSY || state == WAIT_DONE;
        grant    = state == IDLE && en && any && !done && !err;
        fin      = waiting && uart.tx_done;
        tmo      = waiting && !fin && !(state == WAIT_BUSY && uart.tx_busy) && cnt >= 32'(TIMEOUT - 1);
        state_nx = state;
        case (state)
            IDLE:      state_nx = grant ? LOAD : IDLE;
            LOAD:      state_nx = WAIT_BUSY;
            WAIT_BUSY: state_nx = fin || tmo ? IDLE : uart.tx_busy ? WAIT_DONE : WAIT_BUSY;
            WAIT_DONE: state_nx = fin || tmo ? IDLE : WAIT_DONE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            last          <= W'(NREQ - 1);
            grant_id      <= '0;
            cnt           <= '0;
            uart.tx_data  <= '0;
            uart.tx_start <= 1'b0;
            req_ready     <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= state == LOAD ? '0 : waiting ? cnt + 1'b1 : cnt;
            uart.tx_start <= grant;
            req_ready     <= grant ? NREQ'(1) << win : '0;
            done          <= fin;
            err           <= tmo;
            if (grant) begin
                grant_id     <= win;
                uart.tx_data <= lane[win];
            end
            if (fin || tmo) last <= grant_id;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table plus grant scoreboard for uart_tx_arbiter,
// driven by a small behavioural uart_tx that answers each tx_start.
module tb_uart_tx_arbiter;
    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        int          gid;
        logic [7:0]  octet;
        bit          skip;
        int          len;
    } vec_t;
    typedef struct packed {
        logic [1:0] gid;
        logic [7:0] octet;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, en;
    logic [3:0]  req_valid, req_ready;
    logic [31:0] req_data;
    logic [1:0]  grant_id;
    logic        done, err;
    logic        p_rdy = 0, p_st = 0, p_done = 0, p_err = 0;
    logic [7:0]  p_data = 0;
    int          n_tests = 0, n_fail = 0, starts = 0, dones = 0, errs = 0, cyc = 0, last_done = -100;
    int          s0, d0, e0, k;
    bit          model_on, m_skip;
    int          m_lat, m_len;
    exp_t        sb [$];
    exp_t        e;
    vec_t        tv [8];

    uart_tx_arbiter_if u ();

    uart_tx_arbiter #(.NREQ(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .uart(u), .grant_id(grant_id), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_starts(input int target);
        for (int i = 0; i < 200 && starts < target; i++) step();
        chk("start_seen", 32'(starts >= target), 1);
    endtask

    task automatic wait_dones(input int target);
        for (int i = 0; i < 200 && dones < target; i++) step();
        chk("done_seen", 32'(dones >= target), 1);
    endtask

    // scoreboard and pulse-shape monitor
    always @(negedge clk) begin
        if (rst) begin
            cyc++;
            chk("pulse_width", 32'({p_rdy & |req_ready, p_st & u.tx_start, p_done & done, p_err & err}), 0);
            chk("ready_with_start", 32'(|req_ready), 32'(u.tx_start));
            chk("tx_data_hold", 32'((u.tx_data != p_data) && !u.tx_start), 0);
            if (u.tx_start) begin
                starts++;
                chk("idle_gap", 32'(cyc - last_done >= 2), 1);
                chk("sb_nonempty", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("grant_id", 32'(grant_id), 32'(e.gid));
                    chk("tx_data", 32'(u.tx_data), 32'(e.octet));
                    chk("req_ready", 32'(req_ready), 32'(4'(1) << e.gid));
                end
            end
            if (done) begin
                dones++;
                last_done = cyc;
            end
            if (err) errs++;
        end
        p_rdy  = |req_ready;
        p_st   = u.tx_start;
        p_done = done;
        p_err  = err;
        p_data = u.tx_data;
    end

    // behavioural uart_tx: busy after m_lat cycles, done pulse after m_len more
    initial begin
        u.tx_busy = 1'b0;
        u.tx_done = 1'b0;
        forever begin
            step();
            if (model_on && u.tx_start) begin
                repeat (m_lat) step();
                u.tx_busy = !m_skip;
                repeat (m_len) step();
                u.tx_busy = 1'b0;
                u.tx_done = 1'b1;
                step();
                u.tx_done = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tv[0] = '{4'b0001, 32'h0000_0055, 0, 8'h55, 1'b0, 4};
        tv[1] = '{4'b1001, 32'hD3D2_D1D0, 3, 8'hD3, 1'b0, 3};
        tv[2] = '{4'b1001, 32'hC3C2_C1C0, 0, 8'hC0, 1'b0, 5};
        tv[3] = '{4'b1001, 32'hB3B2_B1B0, 3, 8'hB3, 1'b0, 2};
        tv[4] = '{4'b0110, 32'hE3E2_E1E0, 1, 8'hE1, 1'b1, 3};
        tv[5] = '{4'b1111, 32'hF3F2_F1F0, 2, 8'hF2, 1'b0, 1};
        tv[6] = '{4'b0100, 32'h1234_5678, 2, 8'h34, 1'b0, 3};
        tv[7] = '{4'b1010, 32'h9ABC_DEF0, 3, 8'h9A, 1'b0, 6};
        rst = 1'b1; en = 1'b0; req_valid = '0; req_data = '0;
        model_on = 1'b1; m_lat = 1; m_len = 3; m_skip = 1'b0;
        #2 rst = 1'b0;
        #10;
        chk("reset_state", 32'({req_ready, u.tx_start, done, err, grant_id, u.tx_data}), 0);
        step();
        rst = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            m_skip = tv[i].skip;
            m_len  = tv[i].len;
            sb.push_back(exp_t'{2'(tv[i].gid), tv[i].octet});
            req_valid = tv[i].valid;
            req_data  = tv[i].data;
            en = 1'b1;
            d0 = dones; e0 = errs;
            step();
            chk("start_latency", 32'(u.tx_start), 1);
            req_valid = '0;
            wait_dones(d0 + 1);
            chk("no_err", errs, e0);
            step();
        end

        // continuous 1111 requests rotate 0,1,2,3,0
        m_skip = 1'b0; m_len = 3;
        s0 = starts; d0 = dones;
        for (int i = 0; i < 5; i++) sb.push_back(exp_t'{2'(i % 4), 8'hA0 + 8'(i % 4)});
        req_valid = 4'b1111;
        req_data  = 32'hA3A2_A1A0;
        wait_starts(s0 + 5);
        req_valid = '0;
        wait_dones(d0 + 5);
        chk("held_dones", dones - d0, 5);
        step();

        // stalled uart_tx: err after 16 cycles in WAIT_BUSY, then the next requester
        model_on = 1'b0;
        s0 = starts; d0 = dones; e0 = errs;
        sb.push_back(exp_t'{2'd1, 8'h61});
        sb.push_back(exp_t'{2'd2, 8'h62});
        req_valid = 4'b0110;
        req_data  = 32'h6362_6160;
        wait_starts(s0 + 1);
        k = 0;
        while (!err && k < 40) begin
            step();
            k++;
        end
        chk("timeout_cycles", k, 17);
        chk("timeout_no_done", dones, d0);
        chk("timeout_gid", 32'(grant_id), 1);
        model_on = 1'b1;
        wait_starts(s0 + 2);
        req_valid = '0;
        wait_dones(d0 + 1);
        chk("err_count", errs - e0, 1);
        step();

        // en dropped mid-frame: frame completes, grants resume once en returns
        m_len = 8;
        s0 = starts; d0 = dones;
        sb.push_back(exp_t'{2'd0, 8'h70});
        req_valid = 4'b0001;
        req_data  = 32'h7372_7170;
        wait_starts(s0 + 1);
        req_valid = '0;
        repeat (4) step();
        en = 1'b0;
        req_valid = 4'b1000;
        wait_dones(d0 + 1);
        repeat (10) step();
        chk("no_start_en0", starts, s0 + 1);
        sb.push_back(exp_t'{2'd3, 8'h73});
        en = 1'b1;
        step();
        chk("resume_start", 32'(u.tx_start), 1);
        req_valid = '0;
        wait_dones(d0 + 2);
        step();

        // reset in WAIT_DONE, then requester 0 priority is restored
        m_len = 12;
        s0 = starts;
        sb.push_back(exp_t'{2'd0, 8'h80});
        req_valid = 4'b0001;
        req_data  = 32'h8382_8180;
        wait_starts(s0 + 1);
        req_valid = '0;
        repeat (4) step();
        d0 = dones; e0 = errs;
        rst = 1'b0;
        #1;
        chk("rst_outputs", 32'({req_ready, u.tx_start, done, err, grant_id, u.tx_data}), 0);
        repeat (20) step();
        sb.push_back(exp_t'{2'd1, 8'h91});
        req_valid = 4'b0110;
        req_data  = 32'h9392_9190;
        rst = 1'b1;
        step();
        chk("rst_first_start", 32'(u.tx_start), 1);
        chk("rst_no_pulse", (dones - d0) + (errs - e0), 0);
        req_valid = '0;
        wait_dones(d0 + 1);
        repeat (3) step();
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning number of requesters sharing one uart_tx (range 2..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 400000, meaning the clk-cycle limit waiting on uart_tx busy or done (32-bit).
REQ-003 The block SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset (rst=0 resets).
REQ-005 The block SHALL have port en  input  1  grant enable; when low, no new grant is issued.
REQ-006 The block SHALL have port req_valid  input  NREQ  requester i has a byte pending.
REQ-007 The block SHALL have port req_data  input  8*NREQ  byte of requester i at bits [8i+7:8i].
REQ-008 The block SHALL have port req_ready  output  NREQ  one-cycle accept pulse to the granted requester.
REQ-009 The block SHALL have port tx_start  output  1  one-cycle pulse to uart_tx start_trigger.
REQ-010 The block SHALL have port tx_data  output  8  byte to uart_tx data, held stable for the whole frame.
REQ-011 The block SHALL have port tx_busy  input  1  from uart_tx.
REQ-012 The block SHALL have port tx_done  input  1  one-cycle frame-complete pulse from uart_tx.
REQ-013 The block SHALL have port grant_id  output  clog2(NREQ)  index of the current or last granted requester.
REQ-014 The block SHALL have port done  output  1  one-cycle pulse when the granted frame completes.
REQ-015 The block SHALL have port err  output  1  one-cycle pulse on timeout.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
REQ-017 In IDLE, with en=1 and any req_valid set at a rising edge, the FSM SHALL select the winner, latch req_data[winner] into tx_data and grant_id, and move to LOAD.
REQ-018 Winner selection SHALL be round-robin: search from (last_grant+1) mod NREQ upward with wrap-around; the first set bit wins.
REQ-019 In LOAD, which lasts exactly one cycle, the block SHALL assert req_ready[grant_id]=1 and tx_start=1, then move to WAIT_BUSY.
REQ-020 In WAIT_BUSY, tx_busy=1 SHALL move the FSM to WAIT_DONE.
REQ-021 In WAIT_DONE, tx_done=1 SHALL move the FSM to IDLE, with done=1 in the following cycle and last_grant=grant_id.
REQ-022 If tx_done arrives while in WAIT_BUSY, it SHALL be treated as completion, identical to REQ-021.
REQ-023 tx_data SHALL change only on the IDLE->LOAD transition.
REQ-024 req_valid and req_data SHALL be ignored outside IDLE; the requester drops or updates them after its req_ready pulse.
REQ-025 A timeout counter SHALL clear on entering WAIT_BUSY and increment each cycle in WAIT_BUSY and WAIT_DONE.
REQ-026 On timeout (counter reaching TIMEOUT-1 without the exit condition), the FSM SHALL go to IDLE, pulse err=1 for one cycle, and set last_grant=grant_id; done SHALL not pulse.
REQ-027 en=0 SHALL block only the IDLE->LOAD transition; an in-flight frame SHALL complete normally.
REQ-028 Back-to-back traffic: at least one IDLE cycle SHALL separate done from the next tx_start.
REQ-029 req_ready, tx_start, done and err SHALL be registered outputs, never asserted for more than one consecutive cycle.

Reset
REQ-030 rst=0 SHALL asynchronously force state=IDLE, tx_data=0, grant_id=0, last_grant=NREQ-1 (so requester 0 has first priority), timeout counter=0, and req_ready, tx_start, done, err = 0.
REQ-031 Reset during any state SHALL abort the frame without a done or err pulse; the first grant after release SHALL follow REQ-030 priority.

Structure
REQ-032 A shared package SHALL hold the state enumeration, the default TIMEOUT constant, and the GRANT_W=clog2(NREQ) helper.
REQ-033 The round-robin priority search SHALL be a sub-module rr_pick (inputs: request vector, last index; output: winner index and any flag), purely combinational.
REQ-034 The block SHALL connect to uart_tx only through tx_start, tx_data, tx_busy and tx_done.

Verification
REQ-035 Reset, then req_valid=0001 with byte 0x55 -> req_ready=0001 and tx_start each 1 cycle later; tx_data=0x55 stable until done; grant_id=0.
REQ-036 req_valid=1111 held continuously, bytes 0xA0..0xA3 -> grant order 0,1,2,3,0, one done per frame.
REQ-037 last_grant=3 with req_valid=1001 -> requester 0 is granted (wrap), then requester 3.
REQ-038 With tx_busy and tx_done tied low and TIMEOUT=16 -> err pulse 16 cycles after entering WAIT_BUSY, no done, return to IDLE, next requester granted.
REQ-039 en dropped during WAIT_DONE -> frame completes with done; no new tx_start while en=0; grants resume one cycle after en=1.
REQ-040 rst asserted in WAIT_DONE -> all outputs 0 immediately; after release with req_valid=0110, requester 1 is granted.
